contador_checker: RTL and testbench



---
 rtl/contador_pkg.sv | 15 +
 rtl/contador_model.sv | 39 +++
 rtl/contador_checker.sv | 127 ++++++++++++
 tb/tb_contador_checker.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/contador_pkg.sv
// Shared definitions for the contador counter and its checker: mode codes and checker states.
package contador_pkg;

  localparam logic [1:0] MODO_UP    = 2'b00;
  localparam logic [1:0] MODO_DOWN  = 2'b01;
  localparam logic [1:0] MODO_DOWN3 = 2'b10;
  localparam logic [1:0] MODO_LOAD  = 2'b11;

  typedef enum logic [1:0] {
    UNSYNC = 2'b00,
    TRACK  = 2'b01,
    FAULT  = 2'b10
  } chk_state_e;

endpackage : contador_pkg

// File: rtl/contador_model.sv
// Combinational reference of the contador counter: next Q and registered-RCO value from current state.
module contador_model
  import contador_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] q,
  input  logic             enb,
  input  logic [1:0]       modo,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q_nxt_c,
  output logic             rco_nxt_c
);

  localparam int unsigned XW = WIDTH + 1;

  logic [XW-1:0] q_ext;
  logic [XW-1:0] res;

  assign q_ext = {1'b0, q};

  // Extended result: top bit is the carry/borrow, zero for hold and load.
  always_comb begin
    res = q_ext;
    if (enb) begin
      case (modo)
        MODO_UP:    res = q_ext + XW'(1);
        MODO_DOWN:  res = q_ext - XW'(1);
        MODO_DOWN3: res = q_ext - XW'(3);
        MODO_LOAD:  res = {1'b0, d};
        default:    res = q_ext;
      endcase
    end
  end

  assign q_nxt_c   = res[WIDTH-1:0];
  assign rco_nxt_c = res[WIDTH];

endmodule : contador_model

// File: rtl/contador_checker.sv
// Monitor that tracks a contador counter with its own model and flags divergence.
// Define CONTADOR_CHECKER_RCO_EN to also compare RCO against the model.
module contador_checker
  import contador_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned ERR_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enb,
  input  logic [1:0]       modo,
  input  logic [WIDTH-1:0] d,
  input  logic [WIDTH-1:0] q,
  input  logic             rco,
  output logic             synced,
  output logic             mismatch,
  output logic             fault,
  output logic [ERR_W-1:0] err_cnt,
  output logic [WIDTH-1:0] exp_q
);

  chk_state_e       state_q, state_d;
  logic [WIDTH-1:0] exp_q_d;
  logic             synced_d;
  logic             mismatch_d;
  logic             fault_d;
  logic [ERR_W-1:0] err_cnt_d;
  logic [WIDTH-1:0] mdl_q_c;
  logic             mdl_rco_c;
  logic             load_c;
  logic             diff_c;

  contador_model #(
    .WIDTH(WIDTH)
  ) u_model (
    .q        (exp_q),
    .enb      (enb),
    .modo     (modo),
    .d        (d),
    .q_nxt_c  (mdl_q_c),
    .rco_nxt_c(mdl_rco_c)
  );

  assign load_c = enb && (modo == MODO_LOAD);

`ifdef CONTADOR_CHECKER_RCO_EN
  logic exp_rco_q, exp_rco_d;

  assign diff_c = (q != exp_q) || (rco != exp_rco_q);
`else
  logic rco_unused;

  assign rco_unused = rco ^ mdl_rco_c;
  assign diff_c     = (q != exp_q);
`endif

  // Next-state, model advance and error bookkeeping.
  always_comb begin
    state_d    = state_q;
    exp_q_d    = exp_q;
    mismatch_d = 1'b0;
    fault_d    = fault;
    err_cnt_d  = err_cnt;
`ifdef CONTADOR_CHECKER_RCO_EN
    exp_rco_d  = exp_rco_q;
`endif

    case (state_q)
      UNSYNC: begin
        if (load_c) begin
          state_d = TRACK;
          exp_q_d = mdl_q_c;
`ifdef CONTADOR_CHECKER_RCO_EN
          exp_rco_d = mdl_rco_c;
`endif
        end
      end
      TRACK, FAULT: begin
        exp_q_d = mdl_q_c;
`ifdef CONTADOR_CHECKER_RCO_EN
        exp_rco_d = mdl_rco_c;
`endif
        if (diff_c) begin
          state_d    = FAULT;
          mismatch_d = 1'b1;
          fault_d    = 1'b1;
          if (err_cnt != '1) begin
            err_cnt_d = err_cnt + ERR_W'(1);
          end
        end
        // A load re-syncs the model even on the edge that saw an error.
        if (load_c) begin
          state_d = TRACK;
        end
      end
      default: state_d = UNSYNC;
    endcase

    synced_d = (state_d != UNSYNC);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= UNSYNC;
      exp_q    <= '0;
      synced   <= 1'b0;
      mismatch <= 1'b0;
      fault    <= 1'b0;
      err_cnt  <= '0;
`ifdef CONTADOR_CHECKER_RCO_EN
      exp_rco_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      exp_q    <= exp_q_d;
      synced   <= synced_d;
      mismatch <= mismatch_d;
      fault    <= fault_d;
      err_cnt  <= err_cnt_d;
`ifdef CONTADOR_CHECKER_RCO_EN
      exp_rco_q <= exp_rco_d;
`endif
    end
  end

endmodule : contador_checker

// File: tb/tb_contador_checker.sv
// Directed bench for contador_checker: 4-bit main and saturating instances plus a 16-bit instance.
module tb_contador_checker;

`ifdef CONTADOR_CHECKER_RCO_EN
  localparam int RCO_EN = 1;
`else
  localparam int RCO_EN = 0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       enb;
  logic [1:0] modo;
  logic [3:0] d, q;
  logic       rco;

  logic       synced, mismatch, fault;
  logic [7:0] err_cnt;
  logic [3:0] exp_q;

  logic       s_synced, s_mismatch, s_fault;
  logic [1:0] s_err;
  logic [3:0] s_exp_q;

  logic        w_enb;
  logic [1:0]  w_modo;
  logic [15:0] w_d, w_q;
  logic        w_rco;
  logic        w_synced, w_mismatch, w_fault;
  logic [7:0]  w_err;
  logic [15:0] w_exp_q;

  contador_checker #(.WIDTH(4), .ERR_W(8)) u_main (
    .clk(clk), .rst_n(rst_n), .enb(enb), .modo(modo), .d(d), .q(q), .rco(rco),
    .synced(synced), .mismatch(mismatch), .fault(fault), .err_cnt(err_cnt), .exp_q(exp_q)
  );

  contador_checker #(.WIDTH(4), .ERR_W(2)) u_sat (
    .clk(clk), .rst_n(rst_n), .enb(enb), .modo(modo), .d(d), .q(q), .rco(rco),
    .synced(s_synced), .mismatch(s_mismatch), .fault(s_fault), .err_cnt(s_err), .exp_q(s_exp_q)
  );

  contador_checker #(.WIDTH(16), .ERR_W(8)) u_wide (
    .clk(clk), .rst_n(rst_n), .enb(w_enb), .modo(w_modo), .d(w_d), .q(w_q), .rco(w_rco),
    .synced(w_synced), .mismatch(w_mismatch), .fault(w_fault), .err_cnt(w_err), .exp_q(w_exp_q)
  );

  typedef struct {
    logic       enb;
    logic [1:0] modo;
    logic [3:0] d;
    logic [3:0] q;
    logic       rco;
    logic       syn;
    logic       mm;
    logic       flt;
    int         err;
    logic [3:0] eq;
  } vec_t;

  vec_t vecs[$];
  int   n_pass  = 0;
  int   n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic check_main(input string tag, input logic syn, input logic mm,
                            input logic flt, input int err, input logic [3:0] eq);
    int se;
    se = (err > 3) ? 3 : err;
    chk({tag, ".synced"},   32'(synced),   32'(syn));
    chk({tag, ".mismatch"}, 32'(mismatch), 32'(mm));
    chk({tag, ".fault"},    32'(fault),    32'(flt));
    chk({tag, ".err_cnt"},  32'(err_cnt),  32'(err));
    chk({tag, ".exp_q"},    32'(exp_q),    32'(eq));
    chk({tag, ".sat_mm"},   32'(s_mismatch), 32'(mm));
    chk({tag, ".sat_err"},  32'(s_err),    32'(se));
    chk({tag, ".sat_flt"},  32'(s_fault),  32'(flt));
    chk({tag, ".sat_syn"},  32'(s_synced), 32'(syn));
    chk({tag, ".sat_eq"},   32'(s_exp_q),  32'(eq));
  endtask

  task automatic check_wide(input string tag, input logic syn, input logic mm,
                            input int err, input logic [15:0] eq);
    chk({tag, ".w_synced"},   32'(w_synced),   32'(syn));
    chk({tag, ".w_mismatch"}, 32'(w_mismatch), 32'(mm));
    chk({tag, ".w_fault"},    32'(w_fault),    32'(err != 0));
    chk({tag, ".w_err"},      32'(w_err),      32'(err));
    chk({tag, ".w_exp_q"},    32'(w_exp_q),    32'(eq));
  endtask

  task automatic step_main(input logic e, input logic [1:0] m, input logic [3:0] dd,
                           input logic [3:0] qq, input logic r);
    enb = e; modo = m; d = dd; q = qq; rco = r;
    @(posedge clk);
    #1;
  endtask

  task automatic step_wide(input logic e, input logic [1:0] m, input logic [15:0] dd,
                           input logic [15:0] qq, input logic r);
    w_enb = e; w_modo = m; w_d = dd; w_q = qq; w_rco = r;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Fields: enb, modo, d, q(observed), rco(observed) | synced, mismatch, fault, err_cnt, exp_q
    for (int i = 1; i <= 5; i++)
      vecs.push_back('{1'b1, 2'b00, 4'h0, 4'(i), 1'b0,  1'b0, 1'b0, 1'b0, 0, 4'h0});
    vecs.push_back('{1'b1, 2'b11, 4'hE, 4'h5, 1'b0,  1'b1, 1'b0, 1'b0, 0, 4'hE});
    vecs.push_back('{1'b1, 2'b00, 4'h0, 4'hE, 1'b0,  1'b1, 1'b0, 1'b0, 0, 4'hF});
    vecs.push_back('{1'b1, 2'b00, 4'h0, 4'hF, 1'b0,  1'b1, 1'b0, 1'b0, 0, 4'h0});
    vecs.push_back('{1'b1, 2'b00, 4'h0, 4'h0, 1'b1,  1'b1, 1'b0, 1'b0, 0, 4'h1});
    vecs.push_back('{1'b1, 2'b11, 4'h1, 4'h1, 1'b0,  1'b1, 1'b0, 1'b0, 0, 4'h1});
    vecs.push_back('{1'b1, 2'b10, 4'h0, 4'h1, 1'b0,  1'b1, 1'b0, 1'b0, 0, 4'hE});
    vecs.push_back('{1'b0, 2'b00, 4'h0, 4'hD, 1'b1,  1'b1, 1'b1, 1'b1, 1, 4'hE});
    vecs.push_back('{1'b0, 2'b00, 4'h0, 4'hE, 1'b0,  1'b1, 1'b0, 1'b1, 1, 4'hE});
    vecs.push_back('{1'b0, 2'b00, 4'h0, 4'h3, 1'b0,  1'b1, 1'b1, 1'b1, 2, 4'hE});
    vecs.push_back('{1'b0, 2'b00, 4'h0, 4'h4, 1'b0,  1'b1, 1'b1, 1'b1, 3, 4'hE});
    vecs.push_back('{1'b0, 2'b00, 4'h0, 4'h5, 1'b0,  1'b1, 1'b1, 1'b1, 4, 4'hE});
    vecs.push_back('{1'b1, 2'b11, 4'h7, 4'h5, 1'b0,  1'b1, 1'b1, 1'b1, 5, 4'h7});
    vecs.push_back('{1'b0, 2'b00, 4'h0, 4'h7, 1'b0,  1'b1, 1'b0, 1'b1, 5, 4'h7});
    vecs.push_back('{1'b1, 2'b11, 4'h0, 4'h7, 1'b0,  1'b1, 1'b0, 1'b1, 5, 4'h0});
    vecs.push_back('{1'b1, 2'b01, 4'h0, 4'h0, 1'b0,  1'b1, 1'b0, 1'b1, 5, 4'hF});
    vecs.push_back('{1'b1, 2'b00, 4'h0, 4'hF, 1'b1,  1'b1, 1'b0, 1'b1, 5, 4'h0});
    vecs.push_back('{1'b0, 2'b00, 4'h0, 4'h0, 1'b1,  1'b1, 1'b0, 1'b1, 5, 4'h0});
    vecs.push_back('{1'b0, 2'b00, 4'h0, 4'h0, 1'b0,  1'b1, 1'b0, 1'b1, 5, 4'h0});

    rst_n = 1'b0;
    enb = 1'b0; modo = 2'b00; d = '0; q = '0; rco = 1'b0;
    w_enb = 1'b0; w_modo = 2'b00; w_d = '0; w_q = '0; w_rco = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_main("reset", 1'b0, 1'b0, 1'b0, 0, 4'h0);
    check_wide("reset", 1'b0, 1'b0, 0, 16'h0);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      step_main(vecs[i].enb, vecs[i].modo, vecs[i].d, vecs[i].q, vecs[i].rco);
      check_main($sformatf("v%0d", i), vecs[i].syn, vecs[i].mm, vecs[i].flt, vecs[i].err, vecs[i].eq);
    end

    // RCO raised during a hold: only an error when RCO is compared.
    step_main(1'b0, 2'b00, 4'h0, 4'h0, 1'b1);
    check_main("rco_force", 1'b1, 1'(RCO_EN), 1'b1, 5 + RCO_EN, 4'h0);
    step_main(1'b0, 2'b00, 4'h0, 4'h0, 1'b0);
    check_main("rco_clear", 1'b1, 1'b0, 1'b1, 5 + RCO_EN, 4'h0);

    // Mid-run reset with a wrong Q pending: outputs clear at once, nothing is compared afterwards.
    enb = 1'b1; modo = 2'b00; q = 4'h9; rco = 1'b0;
    rst_n = 1'b0;
    #1;
    check_main("rst_mid", 1'b0, 1'b0, 1'b0, 0, 4'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_main("post_rst", 1'b0, 1'b0, 1'b0, 0, 4'h0);
    step_main(1'b1, 2'b00, 4'h0, 4'h3, 1'b1);
    check_main("post_rst2", 1'b0, 1'b0, 1'b0, 0, 4'h0);

    // 16-bit: wrap up from all-ones, then borrow on down-by-3 from 1.
    step_wide(1'b1, 2'b11, 16'hFFFF, 16'h1234, 1'b0);
    check_wide("w_load", 1'b1, 1'b0, 0, 16'hFFFF);
    step_wide(1'b1, 2'b00, 16'h0, 16'hFFFF, 1'b0);
    check_wide("w_up1", 1'b1, 1'b0, 0, 16'h0000);
    step_wide(1'b1, 2'b11, 16'h0001, 16'h0000, 1'b1);
    check_wide("w_wrap", 1'b1, 1'b0, 0, 16'h0001);
    step_wide(1'b1, 2'b10, 16'h0, 16'h0001, 1'b0);
    check_wide("w_dn3", 1'b1, 1'b0, 0, 16'hFFFE);
    step_wide(1'b0, 2'b00, 16'h0, 16'hFFFE, 1'b1);
    check_wide("w_borrow", 1'b1, 1'b0, 0, 16'hFFFE);
    step_wide(1'b0, 2'b00, 16'h0, 16'h0005, 1'b0);
    check_wide("w_bad", 1'b1, 1'b1, 1, 16'hFFFE);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_contador_checker
